logic_unit_pipe: RTL and testbench

//  Parametrised, pipelined bitwise logic unit; successor to the fixed 4-bit combinational unit.

---
 rtl/logic_unit_pipe.sv | 193 +++++++++++++++++++
 tb/tb_logic_unit_pipe.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/logic_unit_pipe.sv
// -----------------------------------------------------------------------------
// logic_unit_pipe
//   Parametrised, two-stage pipelined bitwise logic unit with valid/ready
//   handshakes on both sides. Computes AND/XOR/OR/NOT-B and their inverted
//   forms (NAND/XNOR/NOR/pass-B), flags the result with ZERO and PARITY, and
//   keeps a saturating count of completed output handshakes.
//
//   Stage 1 captures A, B and OP on an input handshake. Stage 2 evaluates the
//   operation from the stage-1 registers and captures S, ZERO and PARITY.
//   Both stages advance independently, so the unit sustains one result per
//   cycle while OUT_READY is held high and stalls cleanly under backpressure.
//
// Ports
//   CLK        in   1      clock, all state updates on rising edge
//   RST        in   1      asynchronous active-high reset
//   IN_VALID   in   1      operands/op presented this cycle
//   IN_READY   out  1      unit accepts operands this cycle (combinational)
//   A          in   WIDTH  operand A (ignored for OP[1:0]=11)
//   B          in   WIDTH  operand B
//   OP         in   3      OP[1:0]: 00 AND, 01 XOR, 10 OR, 11 NOT-B;
//                          OP[2]=1 inverts the result
//   OUT_VALID  out  1      S/ZERO/PARITY valid
//   OUT_READY  in   1      downstream accepts the result
//   S          out  WIDTH  result
//   ZERO       out  1      1 when S is all zeros
//   PARITY     out  1      XOR-reduction of S (1 = odd number of ones)
//   OP_COUNT   out  CNT_W  completed output handshakes, saturating at all-ones
// -----------------------------------------------------------------------------
module logic_unit_pipe #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 16
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             IN_VALID,
   output logic             IN_READY,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [2:0]       OP,
   output logic             OUT_VALID,
   input  logic             OUT_READY,
   output logic [WIDTH-1:0] S,
   output logic             ZERO,
   output logic             PARITY,
   output logic [CNT_W-1:0] OP_COUNT
);

   // Odd-parity indicator of a result word.
   function automatic logic calc_parity(input logic [WIDTH-1:0] val);
      calc_parity = ^val;
   endfunction

   // Bitwise operation: base function picked by op[1:0], optionally inverted by op[2].
   function automatic logic [WIDTH-1:0] calc_result(
      input logic [WIDTH-1:0] a,
      input logic [WIDTH-1:0] b,
      input logic [2:0]       op
   );
      logic [WIDTH-1:0] base;
      case (op[1:0])
         2'b00:   base = a & b;
         2'b01:   base = a ^ b;
         2'b10:   base = a | b;
         2'b11:   base = ~b;
         default: base = {WIDTH{1'b0}};
      endcase
      if (op[2]) begin
         calc_result = ~base;
      end else begin
         calc_result = base;
      end
   endfunction

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   // Stage-1 (operand) registers
   logic             v1_q,  v1_d;
   logic [WIDTH-1:0] a_q,   a_d;
   logic [WIDTH-1:0] b_q,   b_d;
   logic [2:0]       op_q,  op_d;

   // Stage-2 (result) registers
   logic             v2_q,     v2_d;
   logic [WIDTH-1:0] s_q,      s_d;
   logic             zero_q,   zero_d;
   logic             parity_q, parity_d;
   logic [CNT_W-1:0] cnt_q,    cnt_d;

   // Pipeline control
   logic             adv1_s;
   logic             adv2_s;
   logic             out_hs_s;
   logic [WIDTH-1:0] res_s;

   // Stage advance conditions: a stage moves when it is empty or its consumer moves.
   always_comb begin
      adv2_s   = !v2_q || OUT_READY;
      adv1_s   = !v1_q || adv2_s;
      out_hs_s = v2_q && OUT_READY;
      res_s    = calc_result(a_q, b_q, op_q);
   end

   // Stage-1 next state: load operands on an input handshake, bubble otherwise.
   always_comb begin
      v1_d = v1_q;
      a_d  = a_q;
      b_d  = b_q;
      op_d = op_q;
      if (adv1_s) begin
         v1_d = IN_VALID;
         if (IN_VALID) begin
            a_d  = A;
            b_d  = B;
            op_d = OP;
         end else begin
            a_d  = a_q;
            b_d  = b_q;
            op_d = op_q;
         end
      end else begin
         v1_d = v1_q;
      end
   end

   // Stage-2 next state: results only change when a valid stage-1 entry moves in,
   // so S/ZERO/PARITY stay frozen while the output is stalled.
   always_comb begin
      v2_d     = v2_q;
      s_d      = s_q;
      zero_d   = zero_q;
      parity_d = parity_q;
      if (adv2_s) begin
         v2_d = v1_q;
         if (v1_q) begin
            s_d      = res_s;
            zero_d   = (res_s == {WIDTH{1'b0}});
            parity_d = calc_parity(res_s);
         end else begin
            s_d      = s_q;
            zero_d   = zero_q;
            parity_d = parity_q;
         end
      end else begin
         v2_d = v2_q;
      end
   end

   // Completed-operation counter: counts output handshakes and sticks at all-ones.
   always_comb begin
      cnt_d = cnt_q;
      if (out_hs_s && (cnt_q != CNT_MAX)) begin
         cnt_d = cnt_q + CNT_ONE;
      end else begin
         cnt_d = cnt_q;
      end
   end

   // State registers; reset discards any in-flight data.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         v1_q     <= 1'b0;
         a_q      <= {WIDTH{1'b0}};
         b_q      <= {WIDTH{1'b0}};
         op_q     <= 3'b000;
         v2_q     <= 1'b0;
         s_q      <= {WIDTH{1'b0}};
         zero_q   <= 1'b0;
         parity_q <= 1'b0;
         cnt_q    <= {CNT_W{1'b0}};
      end else begin
         v1_q     <= v1_d;
         a_q      <= a_d;
         b_q      <= b_d;
         op_q     <= op_d;
         v2_q     <= v2_d;
         s_q      <= s_d;
         zero_q   <= zero_d;
         parity_q <= parity_d;
         cnt_q    <= cnt_d;
      end
   end

   // IN_READY is deliberately combinational so a full pipeline can accept
   // a new operand in the same cycle the downstream drains one.
   assign IN_READY  = adv1_s;
   assign OUT_VALID = v2_q;
   assign S         = s_q;
   assign ZERO      = zero_q;
   assign PARITY    = parity_q;
   assign OP_COUNT  = cnt_q;

endmodule

// File: tb/tb_logic_unit_pipe.sv
module tb_logic_unit_pipe;

   logic       clk;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] a;
   logic [7:0] b;
   logic [2:0] op;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] s;
   logic       zero;
   logic       parity;
   logic [3:0] op_count;

   // narrow and wide builds
   logic        w1_in_valid, w1_in_ready, w1_out_valid, w1_zero, w1_parity;
   logic [0:0]  w1_a, w1_b, w1_s;
   logic [3:0]  w1_cnt;
   logic        w32_in_valid, w32_in_ready, w32_out_valid, w32_zero, w32_parity;
   logic [31:0] w32_a, w32_b, w32_s;
   logic [3:0]  w32_cnt;
   logic [2:0]  wx_op;
   logic        wx_out_ready;

   int tests_run;
   int tests_failed;

   logic_unit_pipe #(.WIDTH(8), .CNT_W(4)) dut (
      .CLK(clk), .RST(rst), .IN_VALID(in_valid), .IN_READY(in_ready),
      .A(a), .B(b), .OP(op), .OUT_VALID(out_valid), .OUT_READY(out_ready),
      .S(s), .ZERO(zero), .PARITY(parity), .OP_COUNT(op_count)
   );

   logic_unit_pipe #(.WIDTH(1), .CNT_W(4)) dut_w1 (
      .CLK(clk), .RST(rst), .IN_VALID(w1_in_valid), .IN_READY(w1_in_ready),
      .A(w1_a), .B(w1_b), .OP(wx_op), .OUT_VALID(w1_out_valid), .OUT_READY(wx_out_ready),
      .S(w1_s), .ZERO(w1_zero), .PARITY(w1_parity), .OP_COUNT(w1_cnt)
   );

   logic_unit_pipe #(.WIDTH(32), .CNT_W(4)) dut_w32 (
      .CLK(clk), .RST(rst), .IN_VALID(w32_in_valid), .IN_READY(w32_in_ready),
      .A(w32_a), .B(w32_b), .OP(wx_op), .OUT_VALID(w32_out_valid), .OUT_READY(wx_out_ready),
      .S(w32_s), .ZERO(w32_zero), .PARITY(w32_parity), .OP_COUNT(w32_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: result of each of the eight operations written out directly.
   function automatic logic [7:0] ref_s(input logic [7:0] ra, input logic [7:0] rb, input logic [2:0] rop);
      case (rop)
         3'd0: ref_s = ra & rb;
         3'd1: ref_s = ra ^ rb;
         3'd2: ref_s = ra | rb;
         3'd3: ref_s = ~rb;
         3'd4: ref_s = ~(ra & rb);
         3'd5: ref_s = ~(ra ^ rb);
         3'd6: ref_s = ~(ra | rb);
         default: ref_s = rb;
      endcase
   endfunction

   // Packed expectation {S, ZERO, PARITY}
   function automatic logic [9:0] ref_pkt(input logic [7:0] ra, input logic [7:0] rb, input logic [2:0] rop);
      logic [7:0] r;
      r = ref_s(ra, rb, rop);
      ref_pkt = {r, (r == 8'd0), ($countones(r) % 2 == 1)};
   endfunction

   task automatic test_reset;
      rst = 1'b1;
      in_valid = 1'b0; out_ready = 1'b0; a = 8'h00; b = 8'h00; op = 3'd0;
      @(negedge clk); #1;
      tests_run++;
      if ({out_valid, s, zero, parity, op_count} !== 15'd0) begin
         tests_failed++;
         $display("FAIL reset_outputs: got valid=%b s=%h z=%b p=%b cnt=%h, want all 0", out_valid, s, zero, parity, op_count);
      end
      tests_run++;
      if (in_ready !== 1'b1) begin
         tests_failed++;
         $display("FAIL reset_in_ready: got %b want 1", in_ready);
      end
      @(negedge clk);
      rst = 1'b0;
      #1;
      tests_run++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         tests_failed++;
         $display("FAIL post_reset: got in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
      end
   endtask

   task automatic test_all_ops;
      logic [7:0] exp_tab [8];
      exp_tab = '{8'h30, 8'hCC, 8'hFC, 8'hC3, 8'hCF, 8'h33, 8'h03, 8'h3C};
      out_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         in_valid = (i < 8);
         a = 8'hF0; b = 8'h3C; op = 3'(i);
         @(posedge clk);
         @(negedge clk);
         #1;
         tests_run++;
         if (i >= 1 && i <= 8) begin
            if (out_valid !== 1'b1 || s !== exp_tab[i-1] || s !== ref_s(8'hF0, 8'h3C, 3'(i-1))) begin
               tests_failed++;
               $display("FAIL ops_seq[%0d]: got valid=%b s=%h want valid=1 s=%h", i-1, out_valid, s, exp_tab[i-1]);
            end
         end else begin
            if (out_valid !== 1'b0) begin
               tests_failed++;
               $display("FAIL ops_latency[%0d]: got valid=%b want 0", i, out_valid);
            end
         end
      end
      in_valid = 1'b0;
   endtask

   task automatic one_op(input logic [7:0] ta, input logic [7:0] tb, input logic [2:0] top,
                         input logic [9:0] want, input string name);
      int n;
      @(negedge clk);
      in_valid = 1'b1; a = ta; b = tb; op = top; out_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      n = 0;
      while (out_valid !== 1'b1 && n < 10) begin
         @(negedge clk);
         n++;
      end
      #1;
      tests_run++;
      if (out_valid !== 1'b1 || {s, zero, parity} !== want) begin
         tests_failed++;
         $display("FAIL %s: got valid=%b s=%h z=%b p=%b want s=%h z=%b p=%b",
                  name, out_valid, s, zero, parity, want[9:2], want[1], want[0]);
      end
   endtask

   task automatic test_flags;
      one_op(8'h0F, 8'hF0, 3'd0, {8'h00, 1'b1, 1'b0}, "flags_zero");
      one_op(8'h01, 8'h00, 3'd1, {8'h01, 1'b0, 1'b1}, "flags_parity");
   endtask

   task automatic test_backpressure;
      logic [7:0] ea [3];
      logic [7:0] eb [3];
      logic [2:0] eo [3];
      int acc;
      int got;
      ea = '{8'hA5, 8'h5A, 8'hFF}; eb = '{8'h0F, 8'h33, 8'h81}; eo = '{3'd1, 3'd6, 3'd4};
      @(negedge clk);
      out_ready = 1'b0; in_valid = 1'b0;
      @(negedge clk);
      acc = 0;
      // offer operands until the unit refuses one
      for (int c = 0; c < 3; c++) begin
         in_valid = 1'b1; a = ea[acc]; b = eb[acc]; op = eo[acc];
         #1;
         tests_run++;
         if (in_ready !== (c < 2)) begin
            tests_failed++;
            $display("FAIL bp_in_ready[%0d]: got %b want %b", c, in_ready, (c < 2));
         end
         if (in_ready === 1'b1) acc++;
         @(negedge clk);
      end
      // stalled: first result must sit unchanged
      for (int c = 0; c < 3; c++) begin
         #1;
         tests_run++;
         if (out_valid !== 1'b1 || s !== ref_s(ea[0], eb[0], eo[0]) || in_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL bp_stall[%0d]: got valid=%b s=%h rdy=%b want 1/%h/0", c, out_valid, s, in_ready, ref_s(ea[0], eb[0], eo[0]));
         end
         @(negedge clk);
      end
      out_ready = 1'b1;
      got = 0;
      for (int c = 0; c < 8 && got < 3; c++) begin
         #1;
         if (in_valid && in_ready) acc++;
         if (out_valid) begin
            tests_run++;
            if (s !== ref_s(ea[got], eb[got], eo[got])) begin
               tests_failed++;
               $display("FAIL bp_order[%0d]: got %h want %h", got, s, ref_s(ea[got], eb[got], eo[got]));
            end
            got++;
         end
         @(negedge clk);
         if (acc >= 3) in_valid = 1'b0;
      end
      in_valid = 1'b0;
      tests_run++;
      if (got != 3 || acc != 3) begin
         tests_failed++;
         $display("FAIL bp_count: got %0d out %0d in, want 3 3", got, acc);
      end
   endtask

   task automatic test_random;
      logic [9:0] q[$];
      logic [9:0] exp_pkt;
      int accepted, delivered, cyc;
      logic prev_stall;
      logic [7:0] prev_s;
      // clean counter
      @(negedge clk); rst = 1'b1; in_valid = 1'b0;
      @(negedge clk); rst = 1'b0;
      accepted = 0; delivered = 0; cyc = 0; prev_stall = 1'b0; prev_s = 8'h00;
      while ((accepted < 1000 || q.size() != 0) && cyc < 20000) begin
         @(negedge clk);
         cyc++;
         in_valid  = (accepted < 1000) ? ($urandom_range(0, 3) != 0) : 1'b0;
         out_ready = (accepted < 1000) ? ($urandom_range(0, 2) != 0) : 1'b1;
         a = 8'($urandom); b = 8'($urandom); op = 3'($urandom);
         #1;
         tests_run++;
         if (in_ready !== !(q.size() == 2 && !out_ready)) begin
            tests_failed++;
            $display("FAIL rnd_in_ready@%0d: got %b occupancy %0d ordy %b", cyc, in_ready, q.size(), out_ready);
         end
         tests_run++;
         if (op_count !== 4'((delivered > 15) ? 15 : delivered)) begin
            tests_failed++;
            $display("FAIL rnd_count@%0d: got %h want %0d", cyc, op_count, (delivered > 15) ? 15 : delivered);
         end
         if (prev_stall) begin
            tests_run++;
            if (out_valid !== 1'b1 || s !== prev_s) begin
               tests_failed++;
               $display("FAIL rnd_hold@%0d: got valid=%b s=%h want 1/%h", cyc, out_valid, s, prev_s);
            end
         end
         if (out_valid === 1'b1 && out_ready) begin
            tests_run++;
            if (q.size() == 0) begin
               tests_failed++;
               $display("FAIL rnd_dup@%0d: got s=%h with nothing outstanding", cyc, s);
            end else begin
               exp_pkt = q.pop_front();
               if ({s, zero, parity} !== exp_pkt) begin
                  tests_failed++;
                  $display("FAIL rnd_data#%0d: got %h/%b/%b want %h/%b/%b", delivered, s, zero, parity, exp_pkt[9:2], exp_pkt[1], exp_pkt[0]);
               end
            end
            delivered++;
         end
         if (in_valid && in_ready === 1'b1) begin
            q.push_back(ref_pkt(a, b, op));
            accepted++;
         end
         prev_stall = (out_valid === 1'b1) && !out_ready;
         prev_s = s;
      end
      @(negedge clk); in_valid = 1'b0; #1;
      tests_run++;
      if (cyc >= 20000 || delivered != 1000 || op_count !== 4'hF || out_valid !== 1'b0) begin
         tests_failed++;
         $display("FAIL rnd_final: got delivered=%0d cnt=%h valid=%b cycles=%0d want 1000/F/0", delivered, op_count, out_valid, cyc);
      end
   endtask

   task automatic test_reset_midflight;
      @(negedge clk);
      out_ready = 1'b0; in_valid = 1'b1; a = 8'h12; b = 8'h34; op = 3'd2;
      @(negedge clk);
      a = 8'h56;
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      tests_run++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
         tests_failed++;
         $display("FAIL rst_fill: got valid=%b rdy=%b want 1/0", out_valid, in_ready);
      end
      rst = 1'b1;
      #1;
      tests_run++;
      if (out_valid !== 1'b0 || s !== 8'h00 || op_count !== 4'h0 || in_ready !== 1'b1) begin
         tests_failed++;
         $display("FAIL rst_async: got valid=%b s=%h cnt=%h rdy=%b want 0/00/0/1", out_valid, s, op_count, in_ready);
      end
      @(negedge clk);
      rst = 1'b0;
      in_valid = 1'b1; a = 8'hC3; b = 8'h99; op = 3'd5; out_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      tests_run++;
      if (out_valid !== 1'b0) begin
         tests_failed++;
         $display("FAIL rst_stale: got valid=%b s=%h want 0", out_valid, s);
      end
      @(negedge clk); #1;
      tests_run++;
      if (out_valid !== 1'b1 || s !== ref_s(8'hC3, 8'h99, 3'd5) || op_count !== 4'h0) begin
         tests_failed++;
         $display("FAIL rst_first_op: got valid=%b s=%h cnt=%h want 1/%h/0", out_valid, s, op_count, ref_s(8'hC3, 8'h99, 3'd5));
      end
   endtask

   task automatic test_widths;
      @(negedge clk);
      wx_op = 3'b011; wx_out_ready = 1'b1;
      w1_in_valid = 1'b1;  w1_a = 1'($urandom);  w1_b = 1'b1;
      w32_in_valid = 1'b1; w32_a = $urandom;     w32_b = 32'hFFFF_FFFF;
      @(negedge clk);
      w1_in_valid = 1'b0; w32_in_valid = 1'b0;
      @(negedge clk); #1;
      tests_run++;
      if (w1_out_valid !== 1'b1 || w1_s !== 1'b0 || w1_zero !== 1'b1 || w1_parity !== 1'b0) begin
         tests_failed++;
         $display("FAIL width1: got valid=%b s=%b z=%b p=%b want 1/0/1/0", w1_out_valid, w1_s, w1_zero, w1_parity);
      end
      tests_run++;
      if (w32_out_valid !== 1'b1 || w32_s !== 32'd0 || w32_zero !== 1'b1 || w32_parity !== 1'b0) begin
         tests_failed++;
         $display("FAIL width32: got valid=%b s=%h z=%b p=%b want 1/0/1/0", w32_out_valid, w32_s, w32_zero, w32_parity);
      end
   endtask

   initial begin
      tests_run = 0; tests_failed = 0;
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = 8'h00; b = 8'h00; op = 3'd0;
      w1_in_valid = 1'b0; w1_a = 1'b0; w1_b = 1'b0;
      w32_in_valid = 1'b0; w32_a = 32'd0; w32_b = 32'd0;
      wx_op = 3'd0; wx_out_ready = 1'b1;
      test_reset();
      test_all_ops();
      test_flags();
      test_backpressure();
      test_random();
      test_reset_midflight();
      test_widths();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
